// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: captures EX-stage results and MEM/WB control,
// supports stall (hold) and flush (bubble), and derives the branch-taken
// and EX-forwarding match flags from the registered state.
module ex_mem_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [REG_W-1:0]  RegDest_EX,
    input  logic [DATA_W-1:0] ALUResult_EX,
    input  logic [DATA_W-1:0] RtData_EX,
    input  logic [DATA_W-1:0] BranchAddr_EX,
    input  logic              Zero_EX,
    input  logic              RegWrite_EX,
    input  logic              MemtoReg_EX,
    input  logic              MemRead_EX,
    input  logic              MemWrite_EX,
    input  logic              Branch_EX,
    input  logic [REG_W-1:0]  Rs_ID,
    input  logic [REG_W-1:0]  Rt_ID,
    output logic [REG_W-1:0]  RegDest_MEM,
    output logic [DATA_W-1:0] ALUResult_MEM,
    output logic [DATA_W-1:0] RtData_MEM,
    output logic [DATA_W-1:0] BranchAddr_MEM,
    output logic              Zero_MEM,
    output logic              RegWrite_MEM,
    output logic              MemtoReg_MEM,
    output logic              MemRead_MEM,
    output logic              MemWrite_MEM,
    output logic              Branch_MEM,
    output logic              PCSrc_MEM,
    output logic              FwdRs_MEM,
    output logic              FwdRt_MEM
);

    // Register bank: reset and flush both load an all-zero bubble; stall holds.
    always_ff @(posedge Clk) begin
        if (!Rst || Flush) begin
            RegDest_MEM    <= '0;
            ALUResult_MEM  <= '0;
            RtData_MEM     <= '0;
            BranchAddr_MEM <= '0;
            Zero_MEM       <= 1'b0;
            RegWrite_MEM   <= 1'b0;
            MemtoReg_MEM   <= 1'b0;
            MemRead_MEM    <= 1'b0;
            MemWrite_MEM   <= 1'b0;
            Branch_MEM     <= 1'b0;
        end else if (!Stall) begin
            RegDest_MEM    <= RegDest_EX;
            ALUResult_MEM  <= ALUResult_EX;
            RtData_MEM     <= RtData_EX;
            BranchAddr_MEM <= BranchAddr_EX;
            Zero_MEM       <= Zero_EX;
            RegWrite_MEM   <= RegWrite_EX;
            MemtoReg_MEM   <= MemtoReg_EX;
            MemRead_MEM    <= MemRead_EX;
            MemWrite_MEM   <= MemWrite_EX;
            Branch_MEM     <= Branch_EX;
        end
    end

    // Branch-taken and forwarding flags; $0 is never a forwarding source.
    always_comb begin
        PCSrc_MEM = Branch_MEM & Zero_MEM;
        FwdRs_MEM = 1'b0;
        FwdRt_MEM = 1'b0;
        if (RegWrite_MEM && (RegDest_MEM != '0)) begin
            FwdRs_MEM = (RegDest_MEM == Rs_ID);
            FwdRt_MEM = (RegDest_MEM == Rt_ID);
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for the EX/MEM pipeline register: directed cases plus randomized
// traffic compared against a behavioural model of the stage.
module tb_ex_mem_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic          Clk = 1'b0;
    logic          Rst, Stall, Flush;
    logic [RW-1:0] RegDest_EX, Rs_ID, Rt_ID;
    logic [DW-1:0] ALUResult_EX, RtData_EX, BranchAddr_EX;
    logic          Zero_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX;
    logic [RW-1:0] RegDest_MEM;
    logic [DW-1:0] ALUResult_MEM, RtData_MEM, BranchAddr_MEM;
    logic          Zero_MEM, RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM, Branch_MEM;
    logic          PCSrc_MEM, FwdRs_MEM, FwdRt_MEM;

    int checks   = 0;
    int failures = 0;

    // Model of the stage contents as a flat record of fields
    typedef struct {
        logic [RW-1:0] dest;
        logic [DW-1:0] alu, rt, ba;
        logic          zero, rw, mtr, mr, mw, br;
    } stage_t;

    stage_t m;

    ex_mem_stage_reg #(.DATA_W(DW), .REG_W(RW)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .RegDest_EX(RegDest_EX), .ALUResult_EX(ALUResult_EX), .RtData_EX(RtData_EX),
        .BranchAddr_EX(BranchAddr_EX), .Zero_EX(Zero_EX), .RegWrite_EX(RegWrite_EX),
        .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .Branch_EX(Branch_EX), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .RegDest_MEM(RegDest_MEM), .ALUResult_MEM(ALUResult_MEM), .RtData_MEM(RtData_MEM),
        .BranchAddr_MEM(BranchAddr_MEM), .Zero_MEM(Zero_MEM), .RegWrite_MEM(RegWrite_MEM),
        .MemtoReg_MEM(MemtoReg_MEM), .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .Branch_MEM(Branch_MEM), .PCSrc_MEM(PCSrc_MEM), .FwdRs_MEM(FwdRs_MEM),
        .FwdRt_MEM(FwdRt_MEM)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; the model applies reset > flush > stall > load.
    task automatic step();
        @(posedge Clk);
        if (Rst === 1'b0 || Flush === 1'b1) begin
            m = '{dest: '0, alu: '0, rt: '0, ba: '0, zero: 1'b0, rw: 1'b0,
                  mtr: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0};
        end else if (Stall !== 1'b1) begin
            m = '{dest: RegDest_EX, alu: ALUResult_EX, rt: RtData_EX, ba: BranchAddr_EX,
                  zero: Zero_EX, rw: RegWrite_EX, mtr: MemtoReg_EX, mr: MemRead_EX,
                  mw: MemWrite_EX, br: Branch_EX};
        end
        @(negedge Clk);
    endtask

    // Compare every output against the model
    task automatic check_all(input string tag);
        logic exp_pc, exp_frs, exp_frt;
        exp_pc  = m.br && m.zero;
        exp_frs = m.rw && (m.dest != 0) && (m.dest == Rs_ID);
        exp_frt = m.rw && (m.dest != 0) && (m.dest == Rt_ID);
        chk({tag, ".dest"},  DW'(RegDest_MEM), DW'(m.dest));
        chk({tag, ".alu"},   ALUResult_MEM, m.alu);
        chk({tag, ".rt"},    RtData_MEM, m.rt);
        chk({tag, ".ba"},    BranchAddr_MEM, m.ba);
        chk({tag, ".ctl"},   DW'({Zero_MEM, RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM, Branch_MEM}),
                             DW'({m.zero, m.rw, m.mtr, m.mr, m.mw, m.br}));
        chk({tag, ".pcsrc"}, DW'(PCSrc_MEM), DW'(exp_pc));
        chk({tag, ".fwdrs"}, DW'(FwdRs_MEM), DW'(exp_frs));
        chk({tag, ".fwdrt"}, DW'(FwdRt_MEM), DW'(exp_frt));
    endtask

    task automatic set_ex(input logic [RW-1:0] d, input logic [DW-1:0] a, input logic [DW-1:0] r,
                          input logic [DW-1:0] b, input logic [5:0] ctl);
        RegDest_EX = d; ALUResult_EX = a; RtData_EX = r; BranchAddr_EX = b;
        {Zero_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX} = ctl;
    endtask

    task automatic rand_ex();
        set_ex(RW'($urandom_range(0, 31)), $urandom, $urandom, $urandom, 6'($urandom));
        Rs_ID = RW'($urandom_range(0, 3));
        Rt_ID = RW'($urandom_range(0, 3));
    endtask

    initial begin
        // Case 1: reset with all inputs high
        Rst = 1'b0; Stall = 1'b1; Flush = 1'b1;
        set_ex('1, '1, '1, '1, '1);
        Rs_ID = '1; Rt_ID = '1;
        @(negedge Clk);
        step();
        check_all("reset");
        chk("reset.dest_const", DW'(RegDest_MEM), 0);
        chk("reset.fwd_const", DW'({PCSrc_MEM, FwdRs_MEM, FwdRt_MEM}), 0);

        // Case 2: normal load, one cycle latency
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        set_ex(5'd9, 32'h0000_00A5, 32'h1234_5678, 32'h0, 6'b010000);
        Rs_ID = 5'd1; Rt_ID = 5'd2;
        step();
        check_all("load");
        chk("load.dest_const", DW'(RegDest_MEM), 9);
        chk("load.alu_const", ALUResult_MEM, 32'hA5);
        chk("load.rw_const", DW'(RegWrite_MEM), 1);

        // Case 3: stall three cycles while inputs churn, then release
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ex(RW'(i + 3), $urandom, $urandom, $urandom, 6'($urandom));
            step();
            check_all("stall");
            chk("stall.alu_const", ALUResult_MEM, 32'hA5);
        end
        Stall = 1'b0;
        set_ex(5'd17, 32'hDEAD_BEEF, 32'h0, 32'h0, 6'b000000);
        step();
        check_all("unstall");
        chk("unstall.alu_const", ALUResult_MEM, 32'hDEAD_BEEF);

        // Case 4: flush dominates stall
        Stall = 1'b1; Flush = 1'b1;
        set_ex(5'd12, 32'h55, 32'h66, 32'h77, 6'b100011);
        step();
        check_all("flush");
        chk("flush.mw_br_pc", DW'({MemWrite_MEM, Branch_MEM, PCSrc_MEM}), 0);
        chk("flush.dest_const", DW'(RegDest_MEM), 0);

        // Case 5: forwarding flags, changed combinationally on Rs_ID/Rt_ID
        Stall = 1'b0; Flush = 1'b0;
        set_ex(5'd9, 32'h1, 32'h2, 32'h3, 6'b010000);
        Rs_ID = 5'd9; Rt_ID = 5'd9;
        step();
        check_all("fwd_both");
        chk("fwd_both.const", DW'({FwdRs_MEM, FwdRt_MEM}), 3);
        Rt_ID = 5'd10; #1;
        check_all("fwd_rt_miss");
        chk("fwd_rt_miss.const", DW'({FwdRs_MEM, FwdRt_MEM}), 2);
        @(negedge Clk);
        set_ex(5'd0, 32'h1, 32'h2, 32'h3, 6'b010000);
        Rs_ID = 5'd0; Rt_ID = 5'd0;
        step();
        check_all("fwd_r0");
        chk("fwd_r0.const", DW'({FwdRs_MEM, FwdRt_MEM}), 0);
        set_ex(5'd7, 32'h1, 32'h2, 32'h3, 6'b000000);
        Rs_ID = 5'd7; Rt_ID = 5'd7;
        step();
        check_all("fwd_norw");
        chk("fwd_norw.const", DW'({FwdRs_MEM, FwdRt_MEM}), 0);

        // Case 6: taken branch, then reset mid-operation
        set_ex(5'd4, 32'h0, 32'h0, 32'h0040_0020, 6'b100001);
        step();
        check_all("branch");
        chk("branch.pcsrc_const", DW'(PCSrc_MEM), 1);
        chk("branch.ba_const", BranchAddr_MEM, 32'h0040_0020);
        Rst = 1'b0; Stall = 1'b1;
        rand_ex();
        step();
        check_all("midreset");
        chk("midreset.pcsrc_const", DW'(PCSrc_MEM), 0);

        // Randomized traffic with occasional reset, flush and stall
        Rst = 1'b1; Stall = 1'b0;
        for (int n = 0; n < 300; n++) begin
            Rst   = ($urandom_range(0, 31) != 0);
            Flush = ($urandom_range(0, 7) == 0);
            Stall = ($urandom_range(0, 3) == 0);
            rand_ex();
            if ($urandom_range(0, 1) == 1) RegDest_EX = RW'($urandom_range(0, 3));
            step();
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
